// File: rtl/trig_period_meter.sv
// trig_period_meter: trigger edge detector and period / active-phase meter
// fed by the hysteresis comparator output (Compare_SIG).
// Emits a one-cycle trig_out per accepted active edge, measures period and
// active-phase width in clk_in cycles, rejects edges inside the holdoff
// window and aborts with a timeout pulse when no edge arrives in time.
module trig_period_meter #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned HOLDOFF_CYC = 4,
    parameter int unsigned TIMEOUT_CYC = 100000000
) (
    input  logic                 clk_in,
    input  logic                 RST,
    input  logic                 Compare_SIG,
    input  logic                 trig_edge,
    input  logic                 meas_en,
    output logic                 trig_out,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] act_time,
    output logic                 meas_valid,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLDOFF = CNT_WIDTH'(HOLDOFF_CYC);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT = CNT_WIDTH'(TIMEOUT_CYC);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    state_t               state;
    logic                 sig_d;
    logic                 edge_sel;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] phase_lat;

    logic rise;
    logic fall;
    logic act_edge;
    logic opp_edge;
    logic holdoff_ok;

    // Edge classification against the previous sample and the latched polarity
    always_comb begin
        rise       = Compare_SIG & ~sig_d;
        fall       = ~Compare_SIG & sig_d;
        act_edge   = edge_sel ? fall : rise;
        opp_edge   = edge_sel ? rise : fall;
        holdoff_ok = (cnt >= HOLDOFF);
    end

    // Measurement FSM with registered pulse and result outputs
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state      <= IDLE;
            sig_d      <= 1'b0;
            edge_sel   <= 1'b0;
            cnt        <= '0;
            phase_lat  <= '0;
            trig_out   <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            period     <= '0;
            act_time   <= '0;
        end else begin
            sig_d      <= Compare_SIG;
            trig_out   <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (meas_en) begin
                        edge_sel <= trig_edge;
                        state    <= ARM;
                    end
                end

                ARM: begin
                    if (!meas_en) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (act_edge) begin
                        trig_out  <= 1'b1;
                        cnt       <= ONE;
                        phase_lat <= '0;
                        state     <= MEAS;
                    end
                end

                MEAS: begin
                    if (!meas_en) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (act_edge && holdoff_ok) begin
                        period     <= cnt;
                        act_time   <= (phase_lat != '0) ? phase_lat : cnt;
                        meas_valid <= 1'b1;
                        trig_out   <= 1'b1;
                        cnt        <= ONE;
                        phase_lat  <= '0;
                    end else if (act_edge) begin
                        // Glitch inside holdoff: keep counting, forget any phase seen so far
                        cnt       <= cnt + ONE;
                        phase_lat <= '0;
                    end else if (cnt == TIMEOUT) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                        state   <= ARM;
                    end else begin
                        if (opp_edge && (phase_lat == '0) && holdoff_ok) begin
                            phase_lat <= cnt;
                        end
                        cnt <= cnt + ONE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_period_meter.sv
// Directed testbench for trig_period_meter (HOLDOFF_CYC=4, TIMEOUT_CYC=50).
module tb_trig_period_meter;

    localparam int CW = 16;
    localparam int HO = 4;
    localparam int TO = 50;

    logic          clk_in      = 1'b0;
    logic          RST         = 1'b1;
    logic          Compare_SIG = 1'b0;
    logic          trig_edge   = 1'b0;
    logic          meas_en     = 1'b0;
    logic          trig_out;
    logic [CW-1:0] period;
    logic [CW-1:0] act_time;
    logic          meas_valid;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    int n_trig = 0;
    int n_valid = 0;
    int n_tmo = 0;

    // Expected results for the next meas_valid, and the bench's view of the held outputs
    logic [CW-1:0] exp_period = '0;
    logic [CW-1:0] exp_act    = '0;
    logic [CW-1:0] mdl_period = '0;
    logic [CW-1:0] mdl_act    = '0;

    always #5 clk_in = ~clk_in;

    trig_period_meter #(
        .CNT_WIDTH  (CW),
        .HOLDOFF_CYC(HO),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_in     (clk_in),
        .RST        (RST),
        .Compare_SIG(Compare_SIG),
        .trig_edge  (trig_edge),
        .meas_en    (meas_en),
        .trig_out   (trig_out),
        .period     (period),
        .act_time   (act_time),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_trig  = 0;
        n_valid = 0;
        n_tmo   = 0;
    endtask

    // One clock: outputs sampled 1 time unit after the rising edge
    task automatic step();
        logic rst_at_edge;
        rst_at_edge = RST;
        @(posedge clk_in);
        #1;
        if (trig_out)   n_trig++;
        if (timeout)    n_tmo++;
        if (rst_at_edge) begin
            mdl_period = '0;
            mdl_act    = '0;
            check("reset_trig",    trig_out,   0);
            check("reset_valid",   meas_valid, 0);
            check("reset_timeout", timeout,    0);
        end else if (meas_valid) begin
            n_valid++;
            mdl_period = exp_period;
            mdl_act    = exp_act;
            check("valid_with_trig",    trig_out, 1);
            check("valid_with_timeout", timeout,  0);
        end
        check("period_value",   period,   mdl_period);
        check("act_time_value", act_time, mdl_act);
    endtask

    task automatic cyc(input logic s);
        Compare_SIG = s;
        step();
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                Compare_SIG = (j < h);
                step();
            end
        end
    endtask

    initial begin
        // Reset
        step();
        step();
        check("rst_period", period, 0);
        check("rst_act", act_time, 0);
        RST = 1'b0;
        step();
        check("idle_trig", trig_out, 0);

        // Clean square wave, rising edge active: P=10, H=4
        exp_period = 10;
        exp_act    = 4;
        meas_en    = 1'b1;
        step();
        step();
        clear_counts();
        cyc(1'b1);
        check("t1_first_trig", trig_out, 1);
        check("t1_first_no_valid", meas_valid, 0);
        repeat (3) cyc(1'b1);
        repeat (6) cyc(1'b0);
        check("t1_arm_trig_cnt", n_trig, 1);
        check("t1_arm_valid_cnt", n_valid, 0);
        clear_counts();
        wave(10, 4, 3);
        check("t1_trig_cnt", n_trig, 3);
        check("t1_valid_cnt", n_valid, 3);
        check("t1_period", period, 10);
        check("t1_act", act_time, 4);

        // Falling edge active; trig_edge changed after arming has no effect
        meas_en = 1'b0;
        step();
        trig_edge = 1'b1;
        meas_en   = 1'b1;
        step();
        trig_edge = 1'b0;
        exp_act   = 6;
        clear_counts();
        wave(10, 4, 4);
        check("t2_trig_cnt", n_trig, 4);
        check("t2_valid_cnt", n_valid, 3);
        check("t2_period", period, 10);
        check("t2_act", act_time, 6);

        // Glitch rejection, P=20, H=10, low-high glitch 2 cycles after the rise
        meas_en = 1'b0;
        step();
        meas_en = 1'b1;
        step();
        exp_period = 20;
        exp_act    = 10;
        clear_counts();
        wave(20, 10, 1);
        check("t3_arm_trig_cnt", n_trig, 1);
        check("t3_arm_valid_cnt", n_valid, 0);
        clear_counts();
        for (int j = 0; j < 20; j++) cyc((j < 10) && (j != 2));
        check("t3_glitch_trig_cnt", n_trig, 1);
        check("t3_glitch_valid_cnt", n_valid, 1);
        clear_counts();
        cyc(1'b1);
        check("t3_valid", meas_valid, 1);
        check("t3_period", period, 20);
        check("t3_act", act_time, 10);

        // Timeout: one rise then held high
        meas_en     = 1'b0;
        Compare_SIG = 1'b0;
        step();
        meas_en = 1'b1;
        step();
        step();
        clear_counts();
        cyc(1'b1);
        check("t4_trig", trig_out, 1);
        repeat (TO - 1) cyc(1'b1);
        check("t4_no_early_tmo", n_tmo, 0);
        cyc(1'b1);
        check("t4_timeout", timeout, 1);
        check("t4_period_kept", period, 20);
        check("t4_act_kept", act_time, 10);
        check("t4_no_valid", n_valid, 0);
        cyc(1'b1);
        check("t4_tmo_one_cycle", timeout, 0);
        clear_counts();
        exp_period = 12;
        exp_act    = 5;
        repeat (3) cyc(1'b0);
        wave(12, 5, 1);
        check("t4_rearm_trig_cnt", n_trig, 1);
        check("t4_rearm_valid_cnt", n_valid, 0);
        cyc(1'b1);
        check("t4_valid", meas_valid, 1);
        check("t4_period12", period, 12);
        check("t4_act5", act_time, 5);

        // Disable 3 cycles after an accepted edge
        meas_en = 1'b0;
        step();
        Compare_SIG = 1'b0;
        meas_en     = 1'b1;
        step();
        step();
        clear_counts();
        cyc(1'b1);
        check("t5_trig", trig_out, 1);
        cyc(1'b1);
        cyc(1'b1);
        meas_en = 1'b0;
        cyc(1'b1);
        wave(10, 4, 6);
        check("t5_off_trig_cnt", n_trig, 1);
        check("t5_off_valid_cnt", n_valid, 0);
        check("t5_off_tmo_cnt", n_tmo, 0);
        clear_counts();
        exp_period = 15;
        exp_act    = 7;
        meas_en    = 1'b1;
        step();
        wave(15, 7, 2);
        check("t5_trig_cnt", n_trig, 2);
        check("t5_valid_cnt", n_valid, 1);
        check("t5_period", period, 15);
        check("t5_act", act_time, 7);

        // Reset during MEAS
        cyc(1'b1);
        check("t6_pre_valid", meas_valid, 1);
        cyc(1'b1);
        cyc(1'b1);
        RST         = 1'b1;
        Compare_SIG = 1'b0;
        step();
        check("t6_trig", trig_out, 0);
        check("t6_valid", meas_valid, 0);
        check("t6_timeout", timeout, 0);
        check("t6_period", period, 0);
        check("t6_act", act_time, 0);
        RST = 1'b0;
        step();
        clear_counts();
        exp_period = 10;
        exp_act    = 4;
        wave(10, 4, 1);
        check("t6_arm_trig_cnt", n_trig, 1);
        check("t6_arm_valid_cnt", n_valid, 0);
        cyc(1'b1);
        check("t6_valid_after", meas_valid, 1);
        check("t6_period_after", period, 10);
        check("t6_act_after", act_time, 4);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trig_period_meter.md
Name: trig_period_meter

Overview:
- Consumer of the hysteresis comparator's Compare_SIG output.
- Detects the selected trigger edge and emits a one-cycle trigger pulse.
- Measures period and active-phase width in clk_in cycles, with holdoff-based glitch rejection and a no-edge timeout.
- Sits between the comparator and the trigger/frequency readout logic of the instrument.

Parameters:
- CNT_WIDTH, 32, width of the period/active-phase counters and result outputs.
- HOLDOFF_CYC, 4, minimum cycles after an accepted trigger edge before the next active edge is accepted.
- TIMEOUT_CYC, 100000000, cycles without an accepted edge before measurement aborts; must be > HOLDOFF_CYC and < 2^CNT_WIDTH-1.

Ports:
- clk_in, input, 1, sole clock.
- RST, input, 1, synchronous active-high reset.
- Compare_SIG, input, 1, comparator output, synchronous to clk_in.
- trig_edge, input, 1, 0 = rising edge is active, 1 = falling edge is active; sampled on leaving IDLE.
- meas_en, input, 1, level enable for measurement.
- trig_out, output, 1, one-cycle pulse per accepted active edge.
- period, output, CNT_WIDTH, last measured period in cycles.
- act_time, output, CNT_WIDTH, last measured active-phase width: cycles from active edge to opposite edge.
- meas_valid, output, 1, one-cycle pulse when period/act_time update.
- timeout, output, 1, one-cycle pulse on timeout abort.

Behaviour:
- Clock and reset: one clock, clk_in; reset is synchronous and active-high on RST.
- Reset values: all outputs 0, sig_d = 0, cnt = 0, phase_lat = 0, state IDLE, edge_sel = 0. A RST asserted mid-measurement aborts with no meas_valid.
- Edge detection:
  - sig_d registers Compare_SIG every cycle in all states.
  - rise = Compare_SIG & ~sig_d; fall = ~Compare_SIG & sig_d.
  - act_edge = edge_sel ? fall : rise; opp_edge is the other one.
  - If Compare_SIG is first sampled at its new level on clock edge k, trig_out is high for the cycle following edge k (registered, latency 1).
- State IDLE:
  - cnt = 0; trig_out, meas_valid and timeout are held 0.
  - When meas_en = 1: edge_sel <= trig_edge, go to ARM.
- State ARM (waits for the first edge, no result):
  - meas_en = 0: go to IDLE.
  - act_edge: trig_out pulse, cnt <= 1, phase_lat <= 0, go to MEAS.
- State MEAS, evaluated in priority order each cycle:
  - meas_en = 0: go to IDLE next cycle, no pulses.
  - act_edge with cnt >= HOLDOFF_CYC:
    - period <= cnt; act_time <= (phase_lat != 0 ? phase_lat : cnt).
    - meas_valid and trig_out pulse; cnt <= 1; phase_lat <= 0; stay in MEAS.
  - act_edge with cnt < HOLDOFF_CYC: edge ignored; cnt increments; phase_lat is cleared to 0 (glitch reject).
  - cnt == TIMEOUT_CYC: timeout pulse; go to ARM; period and act_time keep their old values.
  - opp_edge with phase_lat == 0 and cnt >= HOLDOFF_CYC: phase_lat <= cnt. An opposite edge inside the holdoff window is ignored.
  - Otherwise cnt <= cnt + 1. The counter never wraps; the timeout is reached first.
- Result values: with a clean input of period P and active width H (both >= HOLDOFF_CYC), period = P and act_time = H exactly.
- Output update timing: period and act_time change only in the cycle meas_valid is asserted, and hold that value otherwise.
- Simultaneous events: act_edge and opp_edge cannot occur in the same cycle. A timeout coinciding with an accepted act_edge is resolved as the edge (priority order above).
- Changing trig_edge while not in IDLE has no effect until the next IDLE → ARM transition.

Test Plan:
- Clean square wave, trig_edge=0:
  - Stimulus: period 10, high 4 cycles; meas_en=1 after reset.
  - Required: first rising edge gives trig_out with no meas_valid.
  - Required: every subsequent rising edge gives meas_valid with period=10, act_time=4; trig_out pulses once per period.
- Same waveform, trig_edge=1: meas_valid with period=10, act_time=6.
- Glitch rejection, HOLDOFF_CYC=4, period-20 wave:
  - Stimulus: a 1-cycle low-high glitch injected 2 cycles after the rising edge.
  - Required: glitch produces no trig_out; next meas_valid reports period=20.
- Timeout, TIMEOUT_CYC=50:
  - Stimulus: one rising edge, then Compare_SIG held high.
  - Required: timeout pulse 50 cycles after trig_out; state returns to ARM; period and act_time unchanged.
  - Required: a later pair of rising edges 12 apart gives period=12.
- Disable mid-measurement:
  - Stimulus: meas_en dropped 3 cycles after an accepted edge.
  - Required: no meas_valid or timeout.
  - Required: after re-enable, the first edge only arms, and the second edge reports the correct period.
- Reset mid-measurement:
  - Stimulus: RST for 1 cycle during MEAS.
  - Required: all outputs 0 the next cycle; no meas_valid until two new accepted edges occur with meas_en=1.
